// File: rtl/output_row_buffer.sv
// ----------------------------------------------------------------------------
// output_row_buffer
//
// Downstream stage of the NPU activation unit. Each activated row arrives as
// a one-cycle pulse with no backpressure toward the producer. The row is
// captured into a small row FIFO. Rows leave the FIFO one element per beat
// over a valid/ready interface toward the output cache / DMA writer.
// A row that arrives while the FIFO is full is dropped, and the sticky
// overflow flag records the drop.
//
// Optional feature (compile-time macro OUTBUF_DROP_COUNT_EN):
//   When the macro is defined, the block adds an 8-bit saturating drop_count
//   output that counts dropped rows. When it is undefined, only the sticky
//   overflow flag reports drops.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   clear       in   synchronous flush of all contents and flags (highest priority)
//   row_in      in   flat row; element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   row_valid   in   row_in is valid this cycle
//   elem_out    out  current element of the head row
//   elem_valid  out  elem_out is valid
//   elem_ready  in   consumer accepts elem_out
//   elem_last   out  elem_out is column MATRIX_SIZE-1 of its row
//   row_count   out  rows stored, counting a partially drained head row
//   full        out  row_count == DEPTH
//   empty       out  row_count == 0
//   overflow    out  sticky; at least one row was dropped
//   drop_count  out  (OUTBUF_DROP_COUNT_EN only) saturating count of dropped rows
// ----------------------------------------------------------------------------
module output_row_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int MATRIX_SIZE = 8,
    parameter int DEPTH       = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] row_in,
    input  logic                              row_valid,
    output logic [DATA_WIDTH-1:0]             elem_out,
    output logic                              elem_valid,
    input  logic                              elem_ready,
    output logic                              elem_last,
    output logic [$clog2(DEPTH):0]            row_count,
    output logic                              full,
    output logic                              empty,
    output logic                              overflow
`ifdef OUTBUF_DROP_COUNT_EN
    ,
    output logic [7:0]                        drop_count
`endif
);

    localparam int ROW_W = MATRIX_SIZE * DATA_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MATRIX_SIZE - 1);

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [ROW_W-1:0]   mem [DEPTH];
    logic [ROW_W-1:0]   head_row;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [COL_W-1:0]   col;
    logic [CNT_W-1:0]   count_next;
    logic               wr_en;
    logic               drop;
    logic               xfer;
    logic               row_done;

    // full is the pre-edge value. A row arriving while full is dropped even if
    // the head row completes at the same edge.
    assign full     = (row_count == CNT_W'(DEPTH));
    assign empty    = (row_count == '0);
    assign wr_en    = row_valid && !full && !clear;
    assign drop     = row_valid && full;

    // The transfer uses the state directly rather than elem_valid. This keeps
    // the output decode and the next-state logic free of any combinational
    // loop between them.
    assign xfer     = (state == S_STREAM) && elem_ready;
    assign row_done = xfer && (col == LAST_COL);
    assign head_row = mem[rd_ptr];

    always_comb begin
        count_next = row_count;
        unique case ({wr_en, row_done})
            2'b10:   count_next = row_count + CNT_W'(1);
            2'b01:   count_next = row_count - CNT_W'(1);
            default: count_next = row_count;  // idle, or a write and a completion together
        endcase
    end

    // NOTE: the row storage has no reset. Valid data is tracked by row_count
    // and the pointers, and elem_out is forced to zero outside STREAM. Stale
    // slot contents therefore never reach the outputs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= row_in;
        end
    end

    // NOTE: registered state uses non-blocking assignments only. Every
    // always_ff then reads the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            col       <= '0;
            row_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            col       <= '0;
            row_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                // DEPTH is a power of two, so the natural wrap is modulo DEPTH.
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (xfer) begin
                if (col == LAST_COL) begin
                    col    <= '0;
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end else begin
                    col    <= col + COL_W'(1);
                end
            end
            row_count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef OUTBUF_DROP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (clear) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

    // Serializer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case. No path
    // leaves a variable unassigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        elem_valid = 1'b0;
        elem_last  = 1'b0;
        elem_out   = '0;
        unique case (state)
            S_EMPTY: begin
                if (wr_en) begin
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                elem_valid = 1'b1;
                elem_last  = (col == LAST_COL);
                elem_out   = head_row[col*DATA_WIDTH +: DATA_WIDTH];
                if (clear || (count_next == '0)) begin
                    state_next = S_EMPTY;
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_output_row_buffer.sv
// ----------------------------------------------------------------------------
// tb_output_row_buffer
//
// Self-checking bench for output_row_buffer. A reference model at posedge
// keeps the number of pending elements. It pushes the expected beats of every
// accepted row into a scoreboard queue. A monitor at negedge pops and compares
// a beat whenever the DUT shows elem_valid && elem_ready. The monitor also
// checks the status outputs against the model every cycle.
// ----------------------------------------------------------------------------
module tb_output_row_buffer;

    localparam int DW    = 16;
    localparam int MS    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [MS*DW-1:0]  row_in = '0;
    logic              row_valid = 1'b0;
    logic [DW-1:0]     elem_out;
    logic              elem_valid;
    logic              elem_ready = 1'b0;
    logic              elem_last;
    logic [CW-1:0]     row_count;
    logic              full;
    logic              empty;
    logic              overflow;
`ifdef OUTBUF_DROP_COUNT_EN
    logic [7:0]        drop_count;
`endif

    always #5 clk = ~clk;

    output_row_buffer #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .row_in     (row_in),
        .row_valid  (row_valid),
        .elem_out   (elem_out),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_last  (elem_last),
        .row_count  (row_count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
`ifdef OUTBUF_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb_q[$];
    int    m_elems = 0;   // elements accepted and not yet transferred
    bit    m_ovf   = 1'b0;
    int    m_drop  = 0;

    function automatic int m_rows();
        return (m_elems + MS - 1) / MS;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int e;
        bit full_before;
        if (!rst_n) begin
            m_elems <= 0;
            m_ovf   <= 1'b0;
            m_drop  <= 0;
            sb_q.delete();
        end else if (clear) begin
            m_elems <= 0;
            m_ovf   <= 1'b0;
            m_drop  <= 0;
            sb_q.delete();
        end else begin
            e = m_elems;
            full_before = (m_rows() == DEPTH);
            if (e > 0 && elem_ready) e = e - 1;
            if (row_valid) begin
                if (full_before) begin
                    m_ovf <= 1'b1;
                    if (m_drop < 255) m_drop <= m_drop + 1;
                end else begin
                    e = e + MS;
                    for (int i = 0; i < MS; i++)
                        sb_q.push_back(beat_t'{data: row_in[i*DW +: DW], last: (i == MS - 1)});
                end
            end
            m_elems <= e;
        end
    end

    // ---------------- monitor ----------------
    logic [DW-1:0] prev_out;
    logic          prev_last;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin : monitor
        beat_t b;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("elem_valid", elem_valid, m_elems > 0);
            check("row_count", row_count, m_rows());
            check("full", full, m_rows() == DEPTH);
            check("empty", empty, m_rows() == 0);
            check("overflow", overflow, m_ovf);
`ifdef OUTBUF_DROP_COUNT_EN
            check("drop_count", drop_count, m_drop);
`endif
            if (prev_stall && elem_valid) begin
                check("stall_data", elem_out, prev_out);
                check("stall_last", elem_last, prev_last);
            end
            if (elem_valid && elem_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat (t=%0t)", elem_out, $time);
                end else begin
                    n_cmp--;
                    b = sb_q.pop_front();
                    check("beat_data", elem_out, b.data);
                    check("beat_last", elem_last, b.last);
                end
            end
            prev_stall = elem_valid && !elem_ready;
            prev_out   = elem_out;
            prev_last  = elem_last;
        end
    end

    // ---------------- ready driver ----------------
    int rmode = 0;  // 0: always ready, 1: 1,0,0,1 pattern, 2: never ready, 3: random
    int rcnt  = 0;

    always @(posedge clk) begin
        #2;
        case (rmode)
            0:       elem_ready = 1'b1;
            1:       elem_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            2:       elem_ready = 1'b0;
            default: elem_ready = 1'($urandom_range(0, 1));
        endcase
        rcnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [MS*DW-1:0] make_row(input int base);
        logic [MS*DW-1:0] r;
        for (int i = 0; i < MS; i++) r[i*DW +: DW] = DW'(base + i);
        return r;
    endfunction

    function automatic logic [MS*DW-1:0] rand_row();
        logic [MS*DW-1:0] r;
        for (int i = 0; i < MS; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic send_row(input logic [MS*DW-1:0] r);
        row_in    = r;
        row_valid = 1'b1;
        tick(1);
        row_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_elem_valid"}, elem_valid, 0);
        check({tag, "_elem_out"}, elem_out, 0);
        check({tag, "_elem_last"}, elem_last, 0);
        check({tag, "_row_count"}, row_count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        tick(2);

        // Single row, always ready: valid one cycle after the write
        rmode = 0;
        tick(1);
        send_row(make_row(1));
        check("latency_valid", elem_valid, 1);
        check("first_elem", elem_out, 16'h0001);
        tick(12);
        check("single_empty", empty, 1);

        // Backpressure 1,0,0,1
        rmode = 1;
        rcnt  = 0;
        send_row(make_row(16'h0101));
        tick(40);
        rmode = 0;
        tick(2);

        // Fill and overflow
        rmode = 2;
        tick(1);
        for (int r = 0; r < 5; r++) send_row(make_row(16'h1000 * (r + 1)));
        tick(2);
        check("fill_full", full, 1);
        check("fill_count", row_count, DEPTH);
        check("fill_overflow", overflow, 1);
`ifdef OUTBUF_DROP_COUNT_EN
        check("fill_drop_count", drop_count, 1);
`endif
        rmode = 0;
        tick(40);

        // Simultaneous write and head-row completion
        send_row(make_row(16'h2000));
        send_row(make_row(16'h2100));
        tick(6);
        send_row(make_row(16'h2200));
        check("simul_count", row_count, 2);
        tick(30);

        // Wrap: 10 rows paced 9 cycles apart
        for (int r = 0; r < 10; r++) begin
            send_row(make_row(16'h3000 + 16 * r));
            tick(8);
        end
        tick(4);

        // Random traffic with random backpressure
        rmode = 3;
        repeat (300) begin
            row_in    = rand_row();
            row_valid = ($urandom_range(0, 5) == 0);
            tick(1);
        end
        row_valid = 1'b0;
        rmode = 0;
        tick(50);

        // Clear mid-row, after an overflow, with row_valid in the same cycle
        rmode = 2;
        tick(1);
        for (int r = 0; r < 5; r++) send_row(make_row(16'h4000 + 16 * r));
        rmode = 0;
        tick(4);
        clear     = 1'b1;
        row_in    = make_row(16'h5000);
        row_valid = 1'b1;
        tick(1);
        clear     = 1'b0;
        row_valid = 1'b0;
        check_reset_values("clear");
        send_row(make_row(16'h6000));
        check("post_clear_col0", elem_out, 16'h6000);
        tick(12);

        // Reset mid-row
        send_row(make_row(16'h7000));
        tick(3);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send_row(make_row(16'h7100));
        tick(12);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Backstop so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/output_row_buffer.md
Name: output_row_buffer

Overview:
- Downstream stage of the activation unit in the NPU datapath.
- Captures each activated row (MATRIX_SIZE Q8.8 elements, one-cycle valid pulse, no backpressure available upstream) into a row FIFO.
- Streams rows out one element per beat over a valid/ready interface toward the output cache / DMA writer.
- Reports fill level and drops on overflow.

Parameters:
- DATA_WIDTH, 16, element width (Q8.8).
- MATRIX_SIZE, 8, elements per row.
- DEPTH, 4, row slots in the FIFO (power of two, at least 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of all contents and flags.
- row_in  in  MATRIX_SIZE*DATA_WIDTH  flat row; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- row_valid  in  1  row_in is valid this cycle.
- elem_out  out  DATA_WIDTH  current element of the head row.
- elem_valid  out  1  elem_out is valid.
- elem_ready  in  1  consumer accepts elem_out.
- elem_last  out  1  elem_out is the final element (column MATRIX_SIZE-1) of its row.
- row_count  out  clog2(DEPTH)+1  rows stored, including a partially drained head row.
- full  out  1  row_count == DEPTH.
- empty  out  1  row_count == 0.
- overflow  out  1  sticky; a row was dropped.

Behaviour:
- Reset and clear values: row_count=0, write/read pointers=0, column index=0, overflow=0, empty=1, full=0, elem_valid=0, elem_last=0, elem_out=0.
- Row write: a row is stored into slot wr_ptr at the edge where row_valid=1 and full=0 (full as sampled before that edge). wr_ptr then increments modulo DEPTH.
- Overflow: row_valid=1 while full=1 drops the row, even if the head row completes draining in the same cycle. overflow sets and stays set until clear or reset.
- Serializer state machine:
  - EMPTY: elem_valid=0. Moves to STREAM the cycle after the first row is written (row_count becomes 1). Write-to-elem_valid latency is 1 cycle.
  - STREAM: elem_valid=1. elem_out = slot[rd_ptr] element col. elem_last = (col==MATRIX_SIZE-1).
- Transfer occurs when elem_valid && elem_ready:
  - If col<MATRIX_SIZE-1: col increments.
  - If col==MATRIX_SIZE-1: col resets to 0, rd_ptr increments modulo DEPTH, row_count decrements. Stay in STREAM if row_count after update > 0, otherwise return to EMPTY.
- Stall: with elem_ready=0, elem_out, elem_last and col hold. No element is skipped or repeated.
- Simultaneous write and row completion in one cycle (not full): row_count unchanged.
- elem_out and elem_last are pure functions of registered state (storage, rd_ptr, col) and must not depend combinationally on elem_ready.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. full and empty derive from row_count, never from pointer equality.
- clear: synchronous, highest priority. A row_valid in the same cycle is discarded and does not set overflow. Valid next cycle is 0.
- Reset mid-stream: the partially drained row is lost; outputs return to reset values asynchronously.

Optional Feature:
- Macro: OUTBUF_DROP_COUNT_EN.
- When defined: adds output port drop_count, 8 bits. It increments on every dropped row, saturates at 255, and clears on reset or clear.
- When undefined: the port and its counter are absent; only the sticky overflow flag reports drops.

Test Plan:
- Single row: write elements 0x0001..0x0008 with elem_ready=1 -> elem_valid rises 1 cycle later; 8 beats in order 0x0001..0x0008; elem_last only on 0x0008; then empty=1, row_count=0.
- Backpressure: same row, elem_ready toggles 1,0,0,1 repeating -> exactly 8 transfers, no duplicates or skips; elem_out stable during every stall.
- Fill and overflow (DEPTH=4): 5 back-to-back rows with elem_ready=0 -> full=1, row_count=4, overflow=1, drop_count=1 if enabled; draining yields rows 1-4 only.
- Simultaneous write and drain: 2 rows queued; row 3 written on the cycle row 1 emits elem_last -> row_count stays 2; output sequence is rows 1, 2, 3 in order.
- Wrap: 10 rows through DEPTH=4 with elem_ready=1 and rows paced 9 cycles apart -> all 80 elements in order; overflow=0.
- Clear and reset mid-row: clear after 3 beats of a row, with row_valid asserted the same cycle -> next cycle empty=1, elem_valid=0, overflow=0, col=0. Repeat with rst_n low instead of clear -> all outputs at reset values immediately.
